// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults
// for the serial pattern detector.
package serial_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 4;

endpackage

// File: rtl/serial_pattern_detector_bit_history.sv
// bit_history: W-bit shift register,
// newest bit enters at the LSB.
module bit_history #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  // shift in one bit per enabled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], d};
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: overlapping
// pattern match with saturating counter.
module serial_pattern_detector
  import serial_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t             state_q;
  state_t             state_d;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      fill_d;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] window;
  logic               armed;
  logic               hit;
  logic               unused_msb;

  bit_history #(
    .W (PAT_LEN)
  ) u_hist (
    .clk (clk),
    .rst (rst),
    .en  (din_valid),
    .d   (din),
    .q   (hist)
  );

  // window includes the bit being sampled now
  assign window     = {hist[PAT_LEN-2:0], din};
  assign unused_msb = hist[PAT_LEN-1];

  // state and fill counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // next state; matching armed once history is full
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    armed   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (din_valid) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == LAST) begin
            state_d = ST_RUN;
            armed   = 1'b1;
          end
        end
      end
      ST_RUN: armed = 1'b1;
      default: ;
    endcase
    hit = armed & din_valid & (window == PATTERN);
  end

  // match pulse and saturating counter; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match <= hit;
      if (clear) begin
        match_count <= '0;
        count_sat   <= 1'b0;
      end else if (hit && match_count != CMAX) begin
        match_count <= match_count + 1'b1;
        if (match_count == CMAX - 1'b1) begin
          count_sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb_serial_pattern_detector: scoreboard bench,
// two builds (PATTERN 1011 and 0000) share stimulus.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       clear = 1'b0;
  logic       m1, s1, m0, s0;
  logic [3:0] c1, c0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit m1; int c1; bit s1;
    bit m0; int c0; bit s0;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit   bits[$];
  int   cnt1, cnt0;

  always #5 clk = ~clk;

  serial_pattern_detector dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .clear       (clear),
    .match       (m1),
    .match_count (c1),
    .count_sat   (s1)
  );

  serial_pattern_detector #(
    .PATTERN (4'b0000)
  ) dut_z (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .clear       (clear),
    .match       (m0),
    .match_count (c0),
    .count_sat   (s0)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    bits.delete();
    cnt1 = 0;
    cnt0 = 0;
  endfunction

  function automatic void push_zero();
    exp_t z;
    z = '{0, 0, 0, 0, 0, 0};
    sb.push_back(z);
  endfunction

  // reference: last four valid bits since reset
  function automatic void model_step(bit v, bit d, bit c);
    exp_t x;
    bit   h1, h0;
    logic [3:0] w;
    h1 = 0;
    h0 = 0;
    if (v) begin
      bits.push_back(d);
      if (bits.size() > 4) void'(bits.pop_front());
      if (bits.size() == 4) begin
        w = {bits[0], bits[1], bits[2], bits[3]};
        h1 = (w == 4'b1011);
        h0 = (w == 4'b0000);
      end
    end
    if (c) cnt1 = 0;
    else if (h1 && cnt1 < 15) cnt1++;
    if (c) cnt0 = 0;
    else if (h0 && cnt0 < 15) cnt0++;
    x = '{h1, cnt1, cnt1 == 15, h0, cnt0, cnt0 == 15};
    sb.push_back(x);
  endfunction

  task automatic cyc(bit v, bit d, bit c);
    @(negedge clk);
    din_valid = v;
    din = d;
    clear = c;
    model_step(v, d, c);
  endtask

  task automatic send(logic [3:0] p);
    for (int i = 3; i >= 0; i--) cyc(1, p[i], 0);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1;
    din_valid = 0;
    clear = 0;
    sb.delete();
    model_reset();
    repeat (n) begin
      push_zero();
      @(negedge clk);
    end
    rst = 0;
    model_step(0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // monitor: one expected record per clock edge
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("match", 32'(m1), 32'(e.m1));
      chk("count", 32'(c1), 32'(e.c1));
      chk("sat", 32'(s1), 32'(e.s1));
      chk("z_match", 32'(m0), 32'(e.m0));
      chk("z_count", 32'(c0), 32'(e.c0));
      chk("z_sat", 32'(s0), 32'(e.s0));
    end
  end

  initial begin
    model_reset();
    do_reset(3);
    repeat (4) cyc(0, 1, 0);
    settle();
    chk("rst_match", 32'(m1), 0);
    chk("rst_count", 32'(c1), 0);

    send(4'b1011);
    cyc(0, 0, 0);
    settle();
    chk("basic_count", 32'(c1), 1);

    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(0, 0, 0); cyc(0, 1, 0);
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    settle();
    chk("overlap_count", 32'(c1), 3);

    cyc(0, 0, 1);
    repeat (16) send(4'b1011);
    cyc(0, 0, 0);
    settle();
    chk("sat_count", 32'(c1), 15);
    chk("sat_flag", 32'(s1), 1);

    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 1, 1);
    settle();
    chk("clr_match", 32'(m1), 1);
    chk("clr_count", 32'(c1), 0);
    chk("clr_sat", 32'(s1), 0);

    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    settle();
    rst = 1;
    #1;
    chk("arst_match", 32'(m1), 0);
    chk("arst_count", 32'(c1), 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    push_zero();
    @(negedge clk);
    rst = 0;
    din_valid = 0;
    clear = 0;
    model_step(0, 0, 0);
    cyc(1, 1, 0);
    settle();
    chk("arst_nohit", 32'(m1), 0);
    send(4'b1011);
    settle();
    chk("arst_refill", 32'(m1), 1);

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0);
      settle();
      chk("fill_zero", 32'(m0), (i >= 3) ? 1 : 0);
    end

    for (int i = 0; i < 400; i++) begin
      bit v, d, c;
      v = ($urandom_range(0, 3) != 0);
      if (i < 200) d = $urandom_range(0, 1) == 1;
      else d = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 30) == 0);
      cyc(v, d, c);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    settle();
    chk("sb_drain", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
